// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types and constants for the DHT11 responder and the
// matching host controller.
//   state_t        responder FSM states
//   FRAME_BITS     bits per DHT11 frame (4 data bytes + checksum)
//   DEF_*          default protocol timing, in microseconds / clk cycles
//   calc_cksum()   DHT11 checksum: byte sum mod 256
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOST_LOW  = 3'd1,
    WAIT_RESP = 3'd2,
    ACK_LOW   = 3'd3,
    ACK_HIGH  = 3'd4,
    BIT_LOW   = 3'd5,
    BIT_HIGH  = 3'd6,
    END_LOW   = 3'd7
  } state_t;

  localparam int FRAME_BITS = 40;

  localparam int DEF_TICK_DIV     = 100;
  localparam int DEF_START_MIN_US = 15000;
  localparam int DEF_RESP_WAIT_US = 30;
  localparam int DEF_SYNC_US      = 80;
  localparam int DEF_BIT_LOW_US   = 50;
  localparam int DEF_ZERO_HIGH_US = 26;
  localparam int DEF_ONE_HIGH_US  = 70;

  // Sum kept in 10 bits so the carry out of the four-byte add is explicit
  // before truncation.
  function automatic logic [7:0] calc_cksum(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3);
    logic [9:0] sum;
    sum = {2'b00, b0} + {2'b00, b1} + {2'b00, b2} + {2'b00, b3};
    return sum[7:0];
  endfunction

endpackage

// File: rtl/dht11_tick_us.sv
// dht11_tick_us: 1 us tick generator.
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   tick   out  one-clk pulse every TICK_DIV clks
module dht11_tick_us #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == CW'(TICK_DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor-side emulator on an open-drain line.
// Waits for a host start pulse, sends the 80/80 us acknowledge, then a
// 40-bit frame {hum_int, hum_dec, tmp_int, tmp_dec, cksum}, MSB first.
//   clk            in     system clock
//   reset          in     asynchronous active-low reset
//   enable         in     responder armed (sampled in IDLE only)
//   hum_int/dec    in     humidity bytes
//   tmp_int/dec    in     temperature bytes
//   cksum_corrupt  in     (DHT11_RESP_CKSUM_ERR_EN only) invert checksum LSB
//   busy           out    start accepted .. frame end
//   frame_done     out    one-clk strobe at end of the end marker; no
//                         back-pressure, a consumer must take it when seen
//   state_dbg      out    current FSM state, for observation only
//   dht_io         inout  open-drain data line, driven 0 or z
// Optional feature macro: DHT11_RESP_CKSUM_ERR_EN.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int START_MIN_US = DEF_START_MIN_US,
  parameter int RESP_WAIT_US = DEF_RESP_WAIT_US,
  parameter int SYNC_US      = DEF_SYNC_US,
  parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
  parameter int ZERO_HIGH_US = DEF_ZERO_HIGH_US,
  parameter int ONE_HIGH_US  = DEF_ONE_HIGH_US
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
`ifdef DHT11_RESP_CKSUM_ERR_EN
  input  logic       cksum_corrupt,
`endif
  output logic       busy,
  output logic       frame_done,
  output state_t     state_dbg,
  inout  wire        dht_io
);

  localparam int CNT_W = 16;

  state_t                  state;
  logic                    oe;
  logic [1:0]              sync_ff;
  logic                    line_s;
  logic                    tick;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        phase_len;
  logic                    phase_end;
  logic [FRAME_BITS-1:0]   shreg;
  logic [5:0]              bitcnt;
  logic [FRAME_BITS-1:0]   frame;
  logic [7:0]              cksum;

  // Open drain: never drive a 1. oe is cleared by the async reset, so the
  // line is released as soon as reset asserts.
  assign dht_io    = oe ? 1'b0 : 1'bz;
  assign state_dbg = state;
  assign line_s    = sync_ff[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_ff <= 2'b11;
    else        sync_ff <= {sync_ff[0], dht_io};
  end

  dht11_tick_us #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef DHT11_RESP_CKSUM_ERR_EN
  assign cksum = calc_cksum(hum_int, hum_dec, tmp_int, tmp_dec) ^ {7'b0, cksum_corrupt};
`else
  assign cksum = calc_cksum(hum_int, hum_dec, tmp_int, tmp_dec);
`endif
  assign frame = {hum_int, hum_dec, tmp_int, tmp_dec, cksum};

  // Length in ticks of the timed phase the FSM is currently in.
  always_comb begin
    phase_len = CNT_W'(1);
    case (state)
      WAIT_RESP:         phase_len = CNT_W'(RESP_WAIT_US);
      ACK_LOW, ACK_HIGH: phase_len = CNT_W'(SYNC_US);
      BIT_LOW, END_LOW:  phase_len = CNT_W'(BIT_LOW_US);
      BIT_HIGH:          phase_len = shreg[FRAME_BITS-1] ? CNT_W'(ONE_HIGH_US)
                                                         : CNT_W'(ZERO_HIGH_US);
      default:           phase_len = CNT_W'(1);
    endcase
  end

  // A phase of N ticks ends on the tick where the count reads N-1.
  assign phase_end = tick && (cnt == phase_len - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      oe         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      bitcnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          oe <= 1'b0;
          if (enable && !line_s) begin
            state <= HOST_LOW;
            cnt   <= '0;
          end
        end
        HOST_LOW: begin
          if (line_s) begin
            if (cnt == CNT_W'(START_MIN_US)) begin
              state  <= WAIT_RESP;
              cnt    <= '0;
              shreg  <= frame;
              bitcnt <= '0;
              busy   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (tick && cnt != CNT_W'(START_MIN_US)) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // Timed response phases: the line is no longer sensed.
          if (phase_end) begin
            cnt <= '0;
            case (state)
              WAIT_RESP: begin state <= ACK_LOW;  oe <= 1'b1; end
              ACK_LOW:   begin state <= ACK_HIGH; oe <= 1'b0; end
              ACK_HIGH:  begin state <= BIT_LOW;  oe <= 1'b1; end
              BIT_LOW:   begin state <= BIT_HIGH; oe <= 1'b0; end
              BIT_HIGH: begin
                shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
                bitcnt <= bitcnt + 1'b1;
                oe     <= 1'b1;
                if (bitcnt == 6'(FRAME_BITS - 1)) state <= END_LOW;
                else                              state <= BIT_LOW;
              end
              END_LOW: begin
                state      <= IDLE;
                oe         <= 1'b0;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
              default: begin
                state <= IDLE;
                oe    <= 1'b0;
              end
            endcase
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: directed bench for dht11_responder. Timing is scaled
// (TICK_DIV=2, START_MIN_US=150) so a full frame is a few thousand clks;
// a 180 us host low stands in for the 18 ms start, 50 us for the 5 ms glitch.
// The driver pushes each expected 40-bit frame into exp_q before releasing
// the host pulse; the monitor decodes the line whenever busy rises and pops.
module tb_dht11_responder;
  import dht11_pkg::*;

  localparam int DIV   = 2;
  localparam int START = 150;
  localparam int HALF  = 5;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
`ifdef DHT11_RESP_CKSUM_ERR_EN
  logic       cksum_corrupt;
`endif
  logic       busy;
  logic       frame_done;
  state_t     state_dbg;
  logic       host_low;
  wire        dht_io;

  pullup (dht_io);
  assign dht_io = host_low ? 1'b0 : 1'bz;

  logic [39:0] exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  bit          mon_abort  = 0;
  bit          mon_busy   = 0;

  dht11_responder #(.TICK_DIV(DIV), .START_MIN_US(START)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .hum_int       (hum_int),
    .hum_dec       (hum_dec),
    .tmp_int       (tmp_int),
    .tmp_dec       (tmp_dec),
`ifdef DHT11_RESP_CKSUM_ERR_EN
    .cksum_corrupt (cksum_corrupt),
`endif
    .busy          (busy),
    .frame_done    (frame_done),
    .state_dbg     (state_dbg),
    .dht_io        (dht_io)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #HALF clk = ~clk;

  // ---------------- checkers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input int w, input int us);
    int d;
    d = w - us * DIV;
    vectors++;
    if (d > DIV || d < -DIV) begin
      miscompares++;
      $display("FAIL %s: width %0d clks expected %0d +/- %0d", name, w, us * DIV, DIV);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    hum_int = a; hum_dec = b; tmp_int = c; tmp_dec = d;
  endtask

  task automatic host_start(input int low_us);
    @(posedge clk);
    host_low = 1'b1;
    repeat (low_us * DIV) @(posedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_busy(input string name, input bit lvl, input int limit);
    int n = 0;
    while (busy !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(busy), 64'(lvl));
  endtask

  task automatic run_frame(input string name, input logic [39:0] exp);
    exp_q.push_back(exp);
    host_start(180);
    wait_busy({name, "_busy_rise"}, 1'b1, 50);
    wait_busy({name, "_busy_fall"}, 1'b0, 20000);
    repeat (20) @(negedge clk);
  endtask

  task automatic no_drive_check(input string name, input int cycles);
    bit bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dht_io !== 1'b1 || busy !== 1'b0) bad = 1;
    end
    check({name, "_no_drive"}, 64'(bad), 64'd0);
    check({name, "_state_idle"}, 64'(state_dbg), 64'(IDLE));
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic meas(input bit lvl, output int w);
    int guard = 0;
    w = 0;
    while (dht_io !== lvl && guard < 4000 && !mon_abort) begin
      @(negedge clk);
      guard++;
    end
    while (dht_io === lvl && w < 4000 && !mon_abort) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic decode_frame();
    int          w;
    int          hw;
    bit          low_bad = 0;
    bit          high_bad = 0;
    logic [39:0] data = '0;
    logic [39:0] exp;
    meas(1'b0, w);
    if (mon_abort) return;
    check_w("ack_low", w, 80);
    meas(1'b1, w);
    if (mon_abort) return;
    check_w("ack_high", w, 80);
    for (int i = 0; i < 40; i++) begin
      meas(1'b0, w);
      if (mon_abort) return;
      if (w < 49 * DIV || w > 51 * DIV) low_bad = 1;
      meas(1'b1, hw);
      if (mon_abort) return;
      if (hw > 48 * DIV) begin
        data = {data[38:0], 1'b1};
        if (hw < 69 * DIV || hw > 71 * DIV) high_bad = 1;
      end else begin
        data = {data[38:0], 1'b0};
        if (hw < 25 * DIV || hw > 27 * DIV) high_bad = 1;
      end
    end
    check("bit_low_widths", 64'(low_bad), 64'd0);
    check("bit_high_widths", 64'(high_bad), 64'd0);
    // End marker; the low is measured up to the high released by the
    // responder, which is the edge that also raises frame_done.
    meas(1'b0, w);
    if (mon_abort) return;
    check_w("end_low", w, 50);
    check("done_pulse", 64'(frame_done), 64'd1);
    check("busy_fall_with_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_single_clk", 64'(frame_done), 64'd0);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_frame: got 0x%010h expected no frame", data);
    end else begin
      exp = exp_q.pop_front();
      check("frame", 64'(data), 64'(exp));
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (busy && !mon_abort) begin
        mon_busy = 1;
        decode_frame();
        mon_busy = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    int n;
    int entries;
    state_t prev;
    reset    = 1'b0;
    enable   = 1'b1;
    host_low = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
`ifdef DHT11_RESP_CKSUM_ERR_EN
    cksum_corrupt = 1'b0;
`endif
    repeat (4) @(negedge clk);
    check("rst_line", 64'(dht_io), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal frame.
    set_data(8'h37, 8'h00, 8'h19, 8'h00);
`ifdef DHT11_RESP_CKSUM_ERR_EN
    cksum_corrupt = 1'b1;
    run_frame("nominal", 40'h37_00_19_00_51);
    cksum_corrupt = 1'b0;
`else
    run_frame("nominal", 40'h37_00_19_00_50);
`endif

    // Short host low: no response.
    host_start(50);
    no_drive_check("glitch", 600);

    // Checksum wrap: 0xFF+0x01+0x80+0x90 = 0x210.
    set_data(8'hFF, 8'h01, 8'h80, 8'h90);
    run_frame("cksum_wrap", 40'hFF_01_80_90_10);

    // Disarmed responder ignores a valid start.
    enable = 1'b0;
    host_start(180);
    no_drive_check("disabled", 600);

    // Re-armed; enable drop and input changes after latch must not matter.
    enable = 1'b1;
    set_data(8'h12, 8'h34, 8'h56, 8'h78);
    exp_q.push_back(40'h12_34_56_78_14);
    host_start(180);
    wait_busy("midframe_busy_rise", 1'b1, 50);
    enable = 1'b0;
    set_data(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    wait_busy("midframe_busy_fall", 1'b0, 20000);
    enable = 1'b1;
    repeat (20) @(negedge clk);

    // Reset during BIT_LOW of bit 12 (13th BIT_LOW entry).
    set_data(8'h37, 8'h00, 8'h19, 8'h00);
    host_start(180);
    wait_busy("rstmid_busy_rise", 1'b1, 50);
    entries = 0;
    n = 0;
    prev = state_dbg;
    while (entries < 13 && n < 20000) begin
      @(negedge clk);
      n++;
      if (state_dbg == BIT_LOW && prev != BIT_LOW) entries++;
      prev = state_dbg;
    end
    check("rstmid_reached_bit12", 64'(entries), 64'd13);
    repeat (3) @(negedge clk);
    #2;
    mon_abort = 1;
    reset = 1'b0;
    #1;
    check("rstmid_line_released", 64'(dht_io), 64'd1);
    check("rstmid_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (mon_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    mon_abort = 0;
    check("rstmid_state", 64'(state_dbg), 64'(IDLE));
    repeat (10) @(negedge clk);

    // Full frame after the aborted one.
    set_data(8'h2A, 8'h05, 8'h1B, 8'h03);
    run_frame("after_reset", 40'h2A_05_1B_03_4D);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Responder-side model of the DHT11 single-wire protocol. It watches the open-drain data line for a host start pulse, answers with the 80 µs / 80 µs acknowledge, and then transmits a 40-bit frame built from its data inputs. It is used as a synthesizable sensor emulator for hardware loopback and as a bench-side responder for host-controller verification.

## Interface
Parameters:
- TICK_DIV, 100: clk cycles per 1 µs tick.
- START_MIN_US, 15000: minimum host low time accepted as a start pulse.
- RESP_WAIT_US, 30: delay from host release to the acknowledge.
- SYNC_US, 80: length of each acknowledge phase (low, then high).
- BIT_LOW_US, 50: low preamble of every bit and of the end marker.
- ZERO_HIGH_US, 26: high time for a '0' bit.
- ONE_HIGH_US, 70: high time for a '1' bit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  responder armed; sampled only in IDLE.
- hum_int  in  8  humidity, integer byte.
- hum_dec  in  8  humidity, decimal byte.
- tmp_int  in  8  temperature, integer byte.
- tmp_dec  in  8  temperature, decimal byte.
- busy  out  1  high from start accepted until frame end.
- frame_done  out  1  one-clk pulse when the end marker completes.
- dht_io  inout  1  open-drain data line: driven 0 or z, never 1. External or bench pull-up required.

## Operation
- dht_io is passed through a 2-FF synchronizer before any use (line_s).
- All durations are counted in 1 µs ticks. A phase of N µs lasts exactly N ticks (count 0..N-1).
- State machine:
  - IDLE: line released.
    - enable=1 and line_s=0 → HOST_LOW, counter cleared.
  - HOST_LOW: count low ticks; the counter saturates at START_MIN_US.
    - line_s=1 with count < START_MIN_US → IDLE (glitch; no response).
    - line_s=1 with count = START_MIN_US → WAIT_RESP. Latch the frame; busy=1.
  - WAIT_RESP: released for RESP_WAIT_US → ACK_LOW.
  - ACK_LOW: drive 0 for SYNC_US → ACK_HIGH.
  - ACK_HIGH: released for SYNC_US → BIT_LOW.
  - BIT_LOW: drive 0 for BIT_LOW_US → BIT_HIGH.
  - BIT_HIGH: released for ZERO_HIGH_US or ONE_HIGH_US, selected by shift-reg MSB.
    - Then shift left; bit counter +1.
    - After bit 39 → END_LOW; otherwise → BIT_LOW.
  - END_LOW: drive 0 for BIT_LOW_US → IDLE. frame_done=1 for one clk; busy=0.
- Frame latch: the 40-bit shift register is loaded with {hum_int, hum_dec, tmp_int, tmp_dec, cksum}, sent MSB first.
  - cksum = (hum_int+hum_dec+tmp_int+tmp_dec) mod 256, computed with 10-bit intermediate and truncated.
  - Input changes after the latch do not affect the frame in flight.
- enable deasserted mid-frame has no effect; the frame completes.
- Host driving the line low during the response is ignored; the responder never senses after WAIT_RESP.
- A new start is accepted only after returning to IDLE.

## Timing
- Reset values:
  - dht_io is released (oe=0).
  - busy=0, frame_done=0.
  - State IDLE; counters, shift register and bit counter all 0.
- Reset asserted mid-frame releases the line immediately (asynchronous), without waiting for a clock.
- Line-sense latency: 2 clk synchronizer plus up to 1 tick of quantization.
- Drive changes occur on the clk edge after the tick that ends a phase.
- Nominal response from host release to the first bit falling edge: RESP_WAIT_US+2·SYNC_US = 190 µs.
- busy rises 1 clk after host release is seen. It falls in the same clk as the frame_done pulse.

## Configuration
- DHT11_RESP_CKSUM_ERR_EN defined: adds input port cksum_corrupt (1 bit), latched with the frame. When it is 1, the transmitted checksum has its LSB inverted, for host error-path testing.
- Undefined: the port is absent and the checksum is always correct.

## Structure
- Package dht11_pkg:
  - state enum (IDLE, HOST_LOW, WAIT_RESP, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW);
  - FRAME_BITS=40;
  - default timing constants shared with the host controller.
- One sub-module: dht11_tick_us, a 1 µs tick generator parameterized by TICK_DIV, with the same active-low asynchronous reset.

## Test plan
- Host low 18 ms then release, with hum=0x37/0x00, tmp=0x19/0x00.
  - Required: ack 80 µs low / 80 µs high.
  - Bits decode to 0x37_00_19_00_50; high widths 26 µs ('0') or 70 µs ('1') ±1 tick.
  - frame_done is a single 1-clk pulse.
- Host low 5 ms → no drive, busy stays 0, state returns to IDLE.
- Inputs 0xFF/0x01/0x80/0x90 → checksum byte 0x10 (wrap of 0x210).
- enable=0 during an 18 ms low → line never driven; enable=1 on the next pulse → normal frame.
- reset asserted during bit 12 BIT_LOW → dht_io is z before the next clk and busy=0. A following 18 ms start yields a complete correct frame.
- With DHT11_RESP_CKSUM_ERR_EN and cksum_corrupt=1 on the first stimulus → checksum byte 0x51.
